// File: rtl/dsp_sys_arr_pkg.sv
// Shared types for the DSP systolic-array datapath.
// Word width is fixed here and used by every buffering stage.
package dsp_sys_arr_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/fifo_mem.sv
// Storage array for sync_word_fifo.
// Synchronous write port, asynchronous read for first-word-fall-through.
module fifo_mem
  import dsp_sys_arr_pkg::*;
#(
  parameter int SIZE = 16,
  parameter int AW   = 4
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  word_t mem [SIZE];

  // Write the tail entry on an accepted push; contents are not reset.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_word_fifo.sv
// Single-clock first-word-fall-through word FIFO.
// Head word is visible combinationally; occupancy and flags are registered.
module sync_word_fifo
  import dsp_sys_arr_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [WORD_W-1:0]      dat_in,
  input  logic                   push,
  input  logic                   pop,
  output logic [WORD_W-1:0]      dat_out,
  output logic                   is_full,
  output logic                   is_empty,
  output logic [$clog2(SIZE):0]  ocp
);

  localparam int PW = $clog2(SIZE);
  localparam int OW = PW + 1;

  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [OW-1:0]     cnt;
  logic              push_ok;
  logic              pop_ok;
  logic [WORD_W-1:0] head;

  // Pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    if (p == PW'(SIZE - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push && (!is_full || pop);
  assign pop_ok  = pop && !is_empty;

  // Pointer and occupancy update; reset wins over any request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wrap_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  fifo_mem #(
    .SIZE (SIZE),
    .AW   (PW)
  ) u_mem (
    .CLK     (CLK),
    .we      (push_ok && !RST),
    .wr_addr (wr_ptr),
    .wr_data (dat_in),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  assign is_full  = (cnt == OW'(SIZE));
  assign is_empty = (cnt == '0);
  assign ocp      = cnt;
  assign dat_out  = is_empty ? '0 : head;

endmodule

// File: tb/tb_sync_word_fifo.sv
// Directed self-checking bench for sync_word_fifo with SIZE=16.
// Inputs change at falling edges; outputs are checked at the next one.
module tb_sync_word_fifo;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] dat_in;
  logic        push;
  logic        pop;
  logic [31:0] dat_out;
  logic        is_full;
  logic        is_empty;
  logic [4:0]  ocp;

  int checks = 0;
  int errors = 0;

  // {is_empty, is_full, ocp, dat_out}
  logic [38:0] st;
  logic [38:0] exp_st;
  assign st = {is_empty, is_full, ocp, dat_out};

  sync_word_fifo #(.SIZE(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .dat_in   (dat_in),
    .push     (push),
    .pop      (pop),
    .dat_out  (dat_out),
    .is_full  (is_full),
    .is_empty (is_empty),
    .ocp      (ocp)
  );

  always #5 CLK = ~CLK;

  task automatic step(input logic p, input logic q, input logic [31:0] d);
    push   = p;
    pop    = q;
    dat_in = d;
    @(negedge CLK);
    push   = 1'b0;
    pop    = 1'b0;
    dat_in = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    exp_st = {1'b1, 1'b0, 5'd0, 32'd0};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL reset: got %h expected %h", st, exp_st);
    end
  endtask

  task automatic test_single();
    step(1'b1, 1'b0, 32'd1);
    exp_st = {1'b0, 1'b0, 5'd1, 32'd1};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL single_push: got %h expected %h", st, exp_st);
    end
    step(1'b0, 1'b1, 32'd0);
    exp_st = {1'b1, 1'b0, 5'd0, 32'd0};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL single_pop: got %h expected %h", st, exp_st);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0, 32'(k));
      exp_st = {1'b0, (k == 16), 5'(k), 32'd1};
      checks++;
      if (st !== exp_st) begin
        errors++;
        $display("FAIL fill_%0d: got %h expected %h", k, st, exp_st);
      end
    end
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b1, 32'd0);
      exp_st = {(k == 16), 1'b0, 5'(16 - k), (k < 16) ? 32'(k + 1) : 32'd0};
      checks++;
      if (st !== exp_st) begin
        errors++;
        $display("FAIL drain_%0d: got %h expected %h", k, st, exp_st);
      end
    end
  endtask

  task automatic test_push_pop_empty();
    do_reset();
    step(1'b1, 1'b1, 32'd1);
    exp_st = {1'b0, 1'b0, 5'd1, 32'd1};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL pushpop_empty: got %h expected %h", st, exp_st);
    end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    for (int k = 1; k <= 16; k++) step(1'b1, 1'b0, 32'(k));
    step(1'b1, 1'b1, 32'd17);
    exp_st = {1'b0, 1'b1, 5'd16, 32'd2};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL pushpop_full: got %h expected %h", st, exp_st);
    end
    for (int j = 1; j <= 15; j++) begin
      step(1'b0, 1'b1, 32'd0);
      exp_st = {1'b0, 1'b0, 5'(16 - j), 32'(j + 2)};
      checks++;
      if (st !== exp_st) begin
        errors++;
        $display("FAIL wrap_pop_%0d: got %h expected %h", j, st, exp_st);
      end
    end
    step(1'b0, 1'b1, 32'd0);
    exp_st = {1'b1, 1'b0, 5'd0, 32'd0};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL wrap_last: got %h expected %h", st, exp_st);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 16; k++) step(1'b1, 1'b0, 32'(k));
    step(1'b1, 1'b0, 32'd17);
    exp_st = {1'b0, 1'b1, 5'd16, 32'd1};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL overflow: got %h expected %h", st, exp_st);
    end
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if (dat_out !== 32'(k)) begin
        errors++;
        $display("FAIL ovf_order_%0d: got %0d expected %0d",
                 k, dat_out, k);
      end
      step(1'b0, 1'b1, 32'd0);
    end
    exp_st = {1'b1, 1'b0, 5'd0, 32'd0};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL ovf_empty: got %h expected %h", st, exp_st);
    end
  endtask

  task automatic test_pop_empty();
    do_reset();
    step(1'b0, 1'b1, 32'd0);
    exp_st = {1'b1, 1'b0, 5'd0, 32'd0};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL pop_empty: got %h expected %h", st, exp_st);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 32'(8'hA0 + k));
    exp_st = {1'b0, 1'b0, 5'd5, 32'hA0};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL pre_reset: got %h expected %h", st, exp_st);
    end
    RST = 1'b1;
    step(1'b1, 1'b1, 32'hDEAD);
    RST = 1'b0;
    exp_st = {1'b1, 1'b0, 5'd0, 32'd0};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL mid_reset: got %h expected %h", st, exp_st);
    end
    step(1'b1, 1'b0, 32'h55);
    exp_st = {1'b0, 1'b0, 5'd1, 32'h55};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL post_reset: got %h expected %h", st, exp_st);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 1'b0, 32'd100);
    step(1'b1, 1'b0, 32'd101);
    step(1'b1, 1'b1, 32'd102);
    exp_st = {1'b0, 1'b0, 5'd2, 32'd101};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL b2b_mid: got %h expected %h", st, exp_st);
    end
  endtask

  initial begin
    RST    = 1'b1;
    push   = 1'b0;
    pop    = 1'b0;
    dat_in = '0;
    @(negedge CLK);
    test_reset();
    test_single();
    test_fill_drain();
    test_push_pop_empty();
    test_push_pop_full();
    test_overflow();
    test_pop_empty();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
